rf_write_ctrl: RTL and testbench
================================

# rf_write_ctrl

Write-port controller for the OTTER register file. It owns the single RF write port and shares it between the pipeline writeback stage and a multi-cycle unit (divider or load return). After every reset, and on request, it sequences a clear of x1..x31 so the register file never holds X state. It sits between the writeback stage and the RF write inputs (`RF_EN`, `RF_WA`, `RF_WD`), and drives `BUSY` and `PIPE_STALL` to the hazard/stall logic.

## Interface
- `DATA_W`, 32, RF data width
- `ADDR_W`, 5, RF address width (2^ADDR_W registers, x0 hard-wired)
- `CLEAR_VAL`, 0, value written to x1..x31 during clear
- `STARVE_MAX`, 4, consecutive refused cycles before `PIPE_STALL` asserts (≥1)

Ports:
- `CLK`  in  1  clock; all state updates on rising edge
- `RST_N`  in  1  asynchronous, active-low reset
- `CLEAR_REQ`  in  1  request a re-clear; sampled only in RUN
- `WB_EN`  in  1  pipeline writeback valid; no ready, always has priority
- `WB_WA`  in  ADDR_W  pipeline writeback address
- `WB_WD`  in  DATA_W  pipeline writeback data
- `MC_VALID`  in  1  multi-cycle unit write request
- `MC_WA`  in  ADDR_W  multi-cycle write address
- `MC_WD`  in  DATA_W  multi-cycle write data
- `MC_READY`  out  1  multi-cycle request accepted this cycle
- `RF_EN`  out  1  RF write enable
- `RF_WA`  out  ADDR_W  RF write address
- `RF_WD`  out  DATA_W  RF write data
- `BUSY`  out  1  clear in progress; pipeline must hold
- `PIPE_STALL`  out  1  registered; pipeline must insert writeback bubbles

## Operation
- States: INIT, CLEAR, RUN. Reset forces INIT, clear counter `cnt`=1, starvation counter 0, `PIPE_STALL`=0.
- INIT: no write; `BUSY`=1, `MC_READY`=0. Next state is CLEAR unconditionally.
- CLEAR: `RF_EN`=1, `RF_WA`=`cnt`, `RF_WD`=`CLEAR_VAL`; `cnt` increments each cycle. When `cnt`=2^ADDR_W−1, the next state is RUN. `BUSY`=1, `MC_READY`=0. `WB_EN` is ignored (dropped) and `CLEAR_REQ` is ignored; no restart occurs.
- RUN arbitration is combinational within the cycle:
  - WB wins when `WB_EN`=1 and `WB_WA`≠0.
  - Otherwise `MC_READY`=1. If `MC_VALID` is also 1, the MC write issues.
  - `RF_EN`=0 for any write to address 0; the handshake still completes.
  - When `RF_EN`=0, `RF_WA` and `RF_WD` are driven 0.
- Same-address WB/MC conflict: WB writes first and MC is refused. Write ordering is guaranteed by the upstream scoreboard, not by this block.
- `CLEAR_REQ`=1 in RUN: the current cycle arbitrates normally. On the next edge, state goes to CLEAR with `cnt`=1 and the starvation counter resets to 0.
- Starvation:
  - The counter increments (saturating at `STARVE_MAX`) on each RUN cycle with `MC_VALID`=1 and `MC_READY`=0.
  - It clears on a completed handshake, on `MC_VALID`=0, or outside RUN.
  - `PIPE_STALL` sets on the edge where the counter reaches `STARVE_MAX`.
  - `PIPE_STALL` clears on the edge of the MC handshake, on `MC_VALID`=0, or on leaving RUN.
- The MC interface obeys valid/ready: once asserted, `MC_VALID`, `MC_WA` and `MC_WD` hold until the handshake. This block does not buffer MC data.

## Timing
- Reset values: `RF_EN`=0, `RF_WA`=0, `RF_WD`=0, `BUSY`=1, `MC_READY`=0, `PIPE_STALL`=0.
- After `RST_N` rises: 1 INIT cycle, then 31 CLEAR write cycles. `BUSY` falls after the 32nd rising edge.
- A reset asserted mid-clear or mid-run takes effect immediately and asynchronously; the sequence restarts from INIT.
- A `CLEAR_REQ` sampled high makes `BUSY` high for exactly 31 cycles.
- WB and MC write latency is 0: the write commits on the same rising edge the request is presented and accepted.
- `PIPE_STALL` is registered: it first asserts on the cycle after the `STARVE_MAX`-th refusal.

## Test plan
- Reset release with `CLEAR_VAL`=0 → `BUSY` high 32 cycles; `RF_EN` pulses with `RF_WA`=1..31 in order; afterwards all RF registers read 0 and x0 is never written.
- In RUN, `WB_EN`=1, `WB_WA`=5, `WB_WD`=0xA5A5A5A5 while `MC_VALID`=1, `MC_WA`=6 → `MC_READY`=0 and x5 is written. The next cycle with `WB_EN`=0 → `MC_READY`=1 and x6 is written with `MC_WD`.
- `WB_WA`=0, `WB_EN`=1, `MC_VALID`=1, `MC_WA`=7 → MC is accepted and x7 is written the same cycle. `MC_WA`=0 → handshake completes with `RF_EN`=0.
- `STARVE_MAX`=4, WB writing x3 every cycle, `MC_VALID` held → `PIPE_STALL` rises after 4 refusals. When WB bubbles, the MC write completes and `PIPE_STALL` falls the next cycle.
- `CLEAR_REQ` pulse in RUN with x9=0x1234 → `BUSY` high 31 cycles and x9 reads `CLEAR_VAL`. A `CLEAR_REQ` issued during that clear does not extend it.
- `RST_N` pulsed low while `cnt`=17 → outputs return to reset values immediately, and the clear restarts from x1 after release.

Source files
------------

// File: rtl/rf_write_ctrl_if.sv
// Bundle of the writeback, multi-cycle and RF write-port signals around
// rf_write_ctrl. The master side is the pipeline/multi-cycle unit.
// The slave side is the controller.
interface rf_write_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              CLEAR_REQ;
    logic              WB_EN;
    logic [ADDR_W-1:0] WB_WA;
    logic [DATA_W-1:0] WB_WD;
    logic              MC_VALID;
    logic [ADDR_W-1:0] MC_WA;
    logic [DATA_W-1:0] MC_WD;
    logic              MC_READY;
    logic              RF_EN;
    logic [ADDR_W-1:0] RF_WA;
    logic [DATA_W-1:0] RF_WD;
    logic              BUSY;
    logic              PIPE_STALL;

    modport master (
        output CLEAR_REQ, WB_EN, WB_WA, WB_WD, MC_VALID, MC_WA, MC_WD,
        input  MC_READY, RF_EN, RF_WA, RF_WD, BUSY, PIPE_STALL
    );

    modport slave (
        input  CLEAR_REQ, WB_EN, WB_WA, WB_WD, MC_VALID, MC_WA, MC_WD,
        output MC_READY, RF_EN, RF_WA, RF_WD, BUSY, PIPE_STALL
    );
endinterface

// File: rtl/rf_write_ctrl.sv
// Register-file write-port controller for OTTER.
// The single RF write port is shared between pipeline writeback and a
// multi-cycle unit. Writeback always has priority.
// After reset, and on CLEAR_REQ, the block sweeps x1..x31 to CLEAR_VAL.
// PIPE_STALL asks the pipeline for bubbles when the multi-cycle unit is
// refused too long.
module rf_write_ctrl #(
    parameter int                DATA_W     = 32,
    parameter int                ADDR_W     = 5,
    parameter logic [DATA_W-1:0] CLEAR_VAL  = {DATA_W{1'b0}},
    parameter int                STARVE_MAX = 4
) (
    input  logic           CLK,
    input  logic           RST_N,
    rf_write_ctrl_if.slave bus
);

    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    localparam logic [ADDR_W-1:0] ADDR_ZERO  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] CNT_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] CNT_LAST   = {ADDR_W{1'b1}};
    localparam logic [DATA_W-1:0] DATA_ZERO  = {DATA_W{1'b0}};
    localparam logic [SW-1:0]     STARVE_ONE = {{(SW-1){1'b0}}, 1'b1};
    localparam logic [SW-1:0]     STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [SW-1:0]     STARVE_ZER = {SW{1'b0}};

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [ADDR_W-1:0] cnt_r;
    logic [SW-1:0]     starve_r;
    logic [SW-1:0]     starve_nxt_s;
    logic              pipe_stall_r;
    logic              stall_nxt_s;

    logic              wb_win_s;
    logic              rf_en_s;
    logic [ADDR_W-1:0] rf_wa_s;
    logic [DATA_W-1:0] rf_wd_s;
    logic              busy_s;
    logic              mc_ready_s;

    // Writeback to x0 is treated as no request, so it never blocks the MC unit.
    assign wb_win_s = bus.WB_EN && (bus.WB_WA != ADDR_ZERO);

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic. A clear always runs to completion once started.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT:  state_nxt_s = ST_CLEAR;
            ST_CLEAR: begin
                if (cnt_r == CNT_LAST) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            ST_RUN: begin
                if (bus.CLEAR_REQ) begin
                    state_nxt_s = ST_CLEAR;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default:  state_nxt_s = ST_INIT;
        endcase
    end

    // Output logic: clear sweep, or same-cycle WB/MC arbitration in RUN.
    always_comb begin
        rf_en_s    = 1'b0;
        rf_wa_s    = ADDR_ZERO;
        rf_wd_s    = DATA_ZERO;
        busy_s     = 1'b1;
        mc_ready_s = 1'b0;
        case (state_r)
            ST_INIT: begin
                busy_s = 1'b1;
            end
            ST_CLEAR: begin
                rf_en_s = 1'b1;
                rf_wa_s = cnt_r;
                rf_wd_s = CLEAR_VAL;
            end
            ST_RUN: begin
                busy_s = 1'b0;
                if (wb_win_s) begin
                    rf_en_s = 1'b1;
                    rf_wa_s = bus.WB_WA;
                    rf_wd_s = bus.WB_WD;
                end else begin
                    mc_ready_s = 1'b1;
                    if (bus.MC_VALID && (bus.MC_WA != ADDR_ZERO)) begin
                        rf_en_s = 1'b1;
                        rf_wa_s = bus.MC_WA;
                        rf_wd_s = bus.MC_WD;
                    end else begin
                        rf_en_s = 1'b0;
                    end
                end
            end
            default: begin
                busy_s = 1'b1;
            end
        endcase
    end

    // Clear address counter. It is held at 1 outside an active sweep, so every clear starts at x1.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cnt_r <= CNT_ONE;
        end else if ((state_r == ST_CLEAR) && (cnt_r != CNT_LAST)) begin
            cnt_r <= cnt_r + CNT_ONE;
        end else begin
            cnt_r <= CNT_ONE;
        end
    end

    // Next starvation count and stall request.
    // Leaving RUN, a handshake, or a dropped request all clear them.
    always_comb begin
        starve_nxt_s = STARVE_ZER;
        stall_nxt_s  = 1'b0;
        if ((state_r != ST_RUN) || (state_nxt_s != ST_RUN)) begin
            starve_nxt_s = STARVE_ZER;
            stall_nxt_s  = 1'b0;
        end else if (bus.MC_VALID && !mc_ready_s) begin
            if (starve_r >= STARVE_LIM) begin
                starve_nxt_s = STARVE_LIM;
            end else begin
                starve_nxt_s = starve_r + STARVE_ONE;
            end
            stall_nxt_s = pipe_stall_r || (starve_nxt_s == STARVE_LIM);
        end else begin
            starve_nxt_s = STARVE_ZER;
            stall_nxt_s  = 1'b0;
        end
    end

    // Starvation counter and registered stall output.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            starve_r     <= STARVE_ZER;
            pipe_stall_r <= 1'b0;
        end else begin
            starve_r     <= starve_nxt_s;
            pipe_stall_r <= stall_nxt_s;
        end
    end

    assign bus.RF_EN      = rf_en_s;
    assign bus.RF_WA      = rf_wa_s;
    assign bus.RF_WD      = rf_wd_s;
    assign bus.BUSY       = busy_s;
    assign bus.MC_READY   = mc_ready_s;
    assign bus.PIPE_STALL = pipe_stall_r;

endmodule

// File: tb/tb_rf_write_ctrl.sv
// Directed testbench for rf_write_ctrl.
// A reference register-file array captures every RF write.
// Outputs are sampled 1 ns after each falling edge.
module tb_rf_write_ctrl;
    localparam int                DATA_W     = 32;
    localparam int                ADDR_W     = 5;
    localparam int                STARVE_MAX = 4;
    localparam logic [DATA_W-1:0] CLEAR_VAL  = 32'h0000_0000;

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;

    rf_write_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    rf_write_ctrl #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .CLEAR_VAL (CLEAR_VAL),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    logic [DATA_W-1:0] rf_m [0:31];
    logic              x0_wr;
    int                n_chk  = 0;
    int                n_fail = 0;
    int                bad;

    // Reference register file: seeded with garbage during reset, then it records RF writes.
    always @(posedge CLK) begin
        if (RST_N === 1'b0) begin
            for (int i = 0; i < 32; i++) rf_m[i] <= 32'hDEAD_BEEF;
            x0_wr <= 1'b0;
        end else if (bus.RF_EN === 1'b1) begin
            rf_m[bus.RF_WA] <= bus.RF_WD;
            if (bus.RF_WA == 5'd0) x0_wr <= 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.CLEAR_REQ = 1'b0;
        bus.WB_EN     = 1'b0;
        bus.WB_WA     = 5'd0;
        bus.WB_WD     = 32'h0;
        bus.MC_VALID  = 1'b0;
        bus.MC_WA     = 5'd0;
        bus.MC_WD     = 32'h0;

        // Reset values.
        #3;
        chk("rst_rf_en", bus.RF_EN, 1'b0);
        chk("rst_rf_wa", bus.RF_WA, 5'd0);
        chk("rst_rf_wd", bus.RF_WD, 32'h0);
        chk("rst_busy", bus.BUSY, 1'b1);
        chk("rst_mc_ready", bus.MC_READY, 1'b0);
        chk("rst_stall", bus.PIPE_STALL, 1'b0);

        // Release reset: 1 INIT cycle, then x1..x31. The WB request below must be ignored.
        @(negedge CLK);
        @(negedge CLK);
        RST_N     = 1'b1;
        bus.WB_EN = 1'b1;
        bus.WB_WA = 5'd2;
        bus.WB_WD = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) begin
            #1;
            chk("init_busy", bus.BUSY, 1'b1);
            chk("init_rf_en", bus.RF_EN, (i != 0));
            chk("init_rf_wa", bus.RF_WA, i);
            chk("init_rf_wd", bus.RF_WD, CLEAR_VAL);
            chk("init_mc_ready", bus.MC_READY, 1'b0);
            @(negedge CLK);
        end
        bus.WB_EN = 1'b0;
        #1;
        chk("run_busy", bus.BUSY, 1'b0);
        chk("run_idle_rf_en", bus.RF_EN, 1'b0);
        chk("run_idle_ready", bus.MC_READY, 1'b1);
        bad = 0;
        for (int i = 1; i < 32; i++) if (rf_m[i] !== CLEAR_VAL) bad++;
        chk("init_all_cleared", bad, 0);
        chk("init_x0_untouched", x0_wr, 1'b0);

        // WB beats MC, then MC goes through when WB is idle.
        @(negedge CLK);
        bus.WB_EN = 1'b1;  bus.WB_WA = 5'd5;  bus.WB_WD = 32'hA5A5_A5A5;
        bus.MC_VALID = 1'b1; bus.MC_WA = 5'd6; bus.MC_WD = 32'h6666_6666;
        #1;
        chk("arb_mc_refused", bus.MC_READY, 1'b0);
        chk("arb_wb_en", bus.RF_EN, 1'b1);
        chk("arb_wb_wa", bus.RF_WA, 5'd5);
        chk("arb_wb_wd", bus.RF_WD, 32'hA5A5_A5A5);
        @(negedge CLK);
        bus.WB_EN = 1'b0;
        #1;
        chk("arb_mc_ready", bus.MC_READY, 1'b1);
        chk("arb_mc_en", bus.RF_EN, 1'b1);
        chk("arb_mc_wa", bus.RF_WA, 5'd6);
        chk("arb_mc_wd", bus.RF_WD, 32'h6666_6666);
        @(negedge CLK);
        bus.MC_VALID = 1'b0;
        #1;
        chk("arb_x5", rf_m[5], 32'hA5A5_A5A5);
        chk("arb_x6", rf_m[6], 32'h6666_6666);
        chk("arb_idle_en", bus.RF_EN, 1'b0);

        // WB to x0 does not block MC; MC to x0 completes without writing.
        @(negedge CLK);
        bus.WB_EN = 1'b1;  bus.WB_WA = 5'd0;  bus.WB_WD = 32'h1111_1111;
        bus.MC_VALID = 1'b1; bus.MC_WA = 5'd7; bus.MC_WD = 32'h7777_7777;
        #1;
        chk("x0wb_mc_ready", bus.MC_READY, 1'b1);
        chk("x0wb_en", bus.RF_EN, 1'b1);
        chk("x0wb_wa", bus.RF_WA, 5'd7);
        chk("x0wb_wd", bus.RF_WD, 32'h7777_7777);
        @(negedge CLK);
        bus.WB_EN = 1'b0; bus.MC_WA = 5'd0; bus.MC_WD = 32'h0BAD_0BAD;
        #1;
        chk("x0mc_ready", bus.MC_READY, 1'b1);
        chk("x0mc_en", bus.RF_EN, 1'b0);
        chk("x0mc_wa", bus.RF_WA, 5'd0);
        chk("x0mc_wd", bus.RF_WD, 32'h0);
        @(negedge CLK);
        bus.MC_VALID = 1'b0;
        #1;
        chk("x0_x7", rf_m[7], 32'h7777_7777);
        chk("x0_never_written", x0_wr, 1'b0);

        // Starvation: WB hammers x3 and MC waits for x8.
        @(negedge CLK);
        bus.WB_EN = 1'b1; bus.WB_WA = 5'd3;
        bus.MC_VALID = 1'b1; bus.MC_WA = 5'd8; bus.MC_WD = 32'h8888_8888;
        for (int k = 1; k <= 6; k++) begin
            bus.WB_WD = k;
            #1;
            chk("starve_stall", bus.PIPE_STALL, (k >= 5));
            chk("starve_refused", bus.MC_READY, 1'b0);
            @(negedge CLK);
        end
        bus.WB_EN = 1'b0;
        #1;
        chk("starve_bubble_ready", bus.MC_READY, 1'b1);
        chk("starve_bubble_stall", bus.PIPE_STALL, 1'b1);
        chk("starve_bubble_wa", bus.RF_WA, 5'd8);
        @(negedge CLK);
        bus.MC_VALID = 1'b0;
        #1;
        chk("starve_stall_fall", bus.PIPE_STALL, 1'b0);
        chk("starve_x8", rf_m[8], 32'h8888_8888);
        chk("starve_x3", rf_m[3], 32'h0000_0006);

        // Re-clear: write x9, pulse CLEAR_REQ, and show a second request does not extend the clear.
        @(negedge CLK);
        bus.WB_EN = 1'b1; bus.WB_WA = 5'd9; bus.WB_WD = 32'h0000_1234;
        #1;
        chk("rc_wb_en", bus.RF_EN, 1'b1);
        @(negedge CLK);
        bus.WB_EN = 1'b0; bus.CLEAR_REQ = 1'b1;
        #1;
        chk("rc_req_busy", bus.BUSY, 1'b0);
        chk("rc_x9_before", rf_m[9], 32'h0000_1234);
        @(negedge CLK);
        for (int i = 0; i < 31; i++) begin
            bus.CLEAR_REQ = (i == 10);
            #1;
            chk("rc_busy", bus.BUSY, 1'b1);
            chk("rc_wa", bus.RF_WA, i + 1);
            @(negedge CLK);
        end
        bus.CLEAR_REQ = 1'b0;
        #1;
        chk("rc_no_extend", bus.BUSY, 1'b0);
        chk("rc_x9_after", rf_m[9], CLEAR_VAL);
        chk("rc_x8_after", rf_m[8], CLEAR_VAL);

        // Asynchronous reset in the middle of a clear, at cnt = 17.
        @(negedge CLK);
        bus.CLEAR_REQ = 1'b1;
        @(negedge CLK);
        bus.CLEAR_REQ = 1'b0;
        for (int i = 0; i < 16; i++) @(negedge CLK);
        #1;
        chk("mid_wa17", bus.RF_WA, 5'd17);
        #2;
        RST_N = 1'b0;
        #1;
        chk("mid_rst_en", bus.RF_EN, 1'b0);
        chk("mid_rst_wa", bus.RF_WA, 5'd0);
        chk("mid_rst_wd", bus.RF_WD, 32'h0);
        chk("mid_rst_busy", bus.BUSY, 1'b1);
        chk("mid_rst_ready", bus.MC_READY, 1'b0);
        chk("mid_rst_stall", bus.PIPE_STALL, 1'b0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        chk("mid_init_en", bus.RF_EN, 1'b0);
        chk("mid_init_busy", bus.BUSY, 1'b1);
        @(negedge CLK);
        #1;
        chk("mid_restart_wa1", bus.RF_WA, 5'd1);
        chk("mid_restart_en", bus.RF_EN, 1'b1);
        @(negedge CLK);
        #1;
        chk("mid_restart_wa2", bus.RF_WA, 5'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
